// File: rtl/id_stage_pipe_if.sv
// Signal bundle between fetch/write-back and the id_stage_pipe decode stage.
// master = fetch/write-back side, slave = the decode stage itself.
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              if_valid;
  logic [31:0]       instruction;
  logic              flush;
  logic              reg_write_in;
  logic [REG_AW-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              stall;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              ex_branch;
  logic              ex_mem_write;
  logic              ex_mem_read;
  logic              ex_alu_src;
  logic              ex_reg_dst;
  logic [1:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_illegal;

  modport master (
    output if_valid, instruction, flush, reg_write_in, write_reg, write_data,
    input  stall, ex_valid, ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_write,
           ex_mem_read, ex_alu_src, ex_reg_dst, ex_alu_op, ex_imm, ex_rs_data,
           ex_rt_data, ex_rs, ex_rt, ex_rd, ex_illegal
  );

  modport slave (
    input  if_valid, instruction, flush, reg_write_in, write_reg, write_data,
    output stall, ex_valid, ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_write,
           ex_mem_read, ex_alu_src, ex_reg_dst, ex_alu_op, ex_imm, ex_rs_data,
           ex_rt_data, ex_rs, ex_rt, ex_rd, ex_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS-subset decode stage: decode, register file, load-use stall, flush, ID/EX register.
// Optional write-back-to-decode bypass enabled by defining ID_STAGE_BYPASS_EN.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  id_stage_pipe_if.slave pipe
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] imm, rs_data, rt_data;
  // ctrl packing: {reg_write, mem_to_reg, branch, mem_write, mem_read, alu_src, alu_op[1:0], reg_dst}
  logic [8:0]        ctrl;
  logic              illegal, uses_rt, hazard, load_en;

  logic [DATA_W-1:0] regs_q [NREG];

  logic              ex_valid_q, ex_valid_d;
  logic [8:0]        ex_ctrl_q, ex_ctrl_d;
  logic              ex_illegal_q, ex_illegal_d;
  logic [DATA_W-1:0] ex_imm_q, ex_rs_data_q, ex_rt_data_q;
  logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;

  assign opcode = pipe.instruction[31:26];
  assign rs     = REG_AW'(pipe.instruction[25:21]);
  assign rt     = REG_AW'(pipe.instruction[20:16]);
  assign rd     = REG_AW'(pipe.instruction[15:11]);

  if (DATA_W > 16) begin : g_sext
    assign imm = {{(DATA_W-16){pipe.instruction[15]}}, pipe.instruction[15:0]};
  end else begin : g_nosext
    assign imm = pipe.instruction[15:0];
  end

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin ctrl = 9'b1_0_0_0_0_0_10_1; uses_rt = 1'b1; end
      OP_LW:          ctrl = 9'b1_1_0_0_1_1_00_0;
      OP_SW:    begin ctrl = 9'b0_0_0_1_0_1_00_0; uses_rt = 1'b1; end
      OP_BEQ:   begin ctrl = 9'b0_0_1_0_0_0_01_0; uses_rt = 1'b1; end
      OP_ADDI:        ctrl = 9'b1_0_0_0_0_1_00_0;
      default:        illegal = 1'b1;
    endcase
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        regs_q[gi] <= '0;
      end else if (pipe.reg_write_in && pipe.write_reg != '0 &&
                   pipe.write_reg == REG_AW'(gi)) begin
        regs_q[gi] <= pipe.write_data;
      end
    end
  end

  always_comb begin
    rs_data = (rs == '0) ? '0 : regs_q[rs];
    rt_data = (rt == '0) ? '0 : regs_q[rt];
`ifdef ID_STAGE_BYPASS_EN
    if (pipe.reg_write_in && pipe.write_reg != '0) begin
      if (pipe.write_reg == rs) rs_data = pipe.write_data;
      if (pipe.write_reg == rt) rt_data = pipe.write_data;
    end
`endif
  end

  // Load-use: the load in ID/EX targets a register this instruction actually reads.
  assign hazard = ex_valid_q & ex_ctrl_q[4] & pipe.if_valid & ~pipe.flush &
                  (ex_rt_q != '0) &
                  ((ex_rt_q == rs) | ((ex_rt_q == rt) & uses_rt));
  assign load_en = pipe.if_valid & ~pipe.flush & ~hazard;

  assign ex_valid_d   = load_en;
  assign ex_ctrl_d    = load_en ? ctrl : '0;
  assign ex_illegal_d = load_en & illegal;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_illegal_q <= 1'b0;
      ex_imm_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_illegal_q <= ex_illegal_d;
      ex_imm_q     <= imm;
      ex_rs_data_q <= rs_data;
      ex_rt_data_q <= rt_data;
      ex_rs_q      <= rs;
      ex_rt_q      <= rt;
      ex_rd_q      <= rd;
    end
  end

  assign pipe.stall         = hazard;
  assign pipe.ex_valid      = ex_valid_q;
  assign pipe.ex_reg_write  = ex_ctrl_q[8];
  assign pipe.ex_mem_to_reg = ex_ctrl_q[7];
  assign pipe.ex_branch     = ex_ctrl_q[6];
  assign pipe.ex_mem_write  = ex_ctrl_q[5];
  assign pipe.ex_mem_read   = ex_ctrl_q[4];
  assign pipe.ex_alu_src    = ex_ctrl_q[3];
  assign pipe.ex_alu_op     = ex_ctrl_q[2:1];
  assign pipe.ex_reg_dst    = ex_ctrl_q[0];
  assign pipe.ex_illegal    = ex_illegal_q;
  assign pipe.ex_imm        = ex_imm_q;
  assign pipe.ex_rs_data    = ex_rs_data_q;
  assign pipe.ex_rt_data    = ex_rt_data_q;
  assign pipe.ex_rs         = ex_rs_q;
  assign pipe.ex_rt         = ex_rt_q;
  assign pipe.ex_rd         = ex_rd_q;
endmodule
